// File: rtl/conv2_relu_pool_pkg.sv
// Shared CNN constants and helpers for the conv-layer post-processing blocks.
// Latency: n/a (constants and pure combinational functions only).
// Backpressure: n/a.
package conv2_relu_pool_pkg;

  // Width of the pooled output word; the top bit is always zero.
  localparam int POOL_W = 12;
  // Width of an activation after ReLU and saturation.
  localparam int RELU_W = 11;
  // Largest activation value; larger sums are clamped to this.
  localparam logic [RELU_W-1:0] SAT_MAX = 11'd2047;

  // ReLU with upper saturation on a 15-bit two's-complement sum.
  function automatic logic [RELU_W-1:0] relu_sat(input logic [14:0] s);
    logic [RELU_W-1:0] r;
    if (s[14]) begin
      r = '0;
    end else if (|s[13:RELU_W]) begin
      r = SAT_MAX;
    end else begin
      r = s[RELU_W-1:0];
    end
    return r;
  endfunction

  // Unsigned maximum of two activations.
  function automatic logic [RELU_W-1:0] max2(input logic [RELU_W-1:0] a,
                                             input logic [RELU_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Row buffer holding the top-row pair maxima of each 2x2 pooling window.
// Latency: write lands on the next rising edge; read is combinational from raddr.
// Backpressure: none; caller guarantees a write precedes any read of an entry.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module pool_line_buf #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 11,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: every entry is rewritten on an even row before its odd-row read.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv2_relu_pool.sv
// Bias + ReLU/saturation on a raster pixel stream, followed by 2x2 max pooling.
// Latency: one cycle from the pixel completing a window to valid_out.
// Backpressure: none; valid_in strobes may arrive with arbitrary gaps.
// Ports: clk, rst_n (async active-low); valid_in/conv_in pixel input;
//        pool_out/valid_out pooled result; frame_done marks the last result.
module conv2_relu_pool
  import conv2_relu_pool_pkg::*;
#(
  parameter int                 IMG_W = 12,
  parameter int                 IMG_H = 12,
  parameter logic signed [13:0] BIAS  = 14'sd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [13:0]       conv_in,
  output logic [POOL_W-1:0] pool_out,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [RELU_W-1:0] h;

  logic [14:0]       s;
  logic [RELU_W-1:0] r;
  logic [RELU_W-1:0] pair_max;
  logic [RELU_W-1:0] buf_rd;
  logic [RELU_W-1:0] win_max;
  logic              last_col;
  logic              last_row;
  logic              buf_we;
  logic              win_done;
  logic [AW-1:0]     buf_addr;

  // Sign-extend both operands to 15 bits so the sum can never overflow.
  assign s        = {conv_in[13], conv_in} + {BIAS[13], BIAS};
  assign r        = relu_sat(s);
  assign pair_max = max2(h, r);
  assign win_max  = max2(buf_rd, pair_max);

  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));
  assign buf_addr = AW'(col >> 1);

  // Odd column closes a horizontal pair: even rows park it, odd rows emit.
  assign buf_we   = valid_in && col[0] && !row[0];
  assign win_done = valid_in && col[0] && row[0];

  pool_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (RELU_W),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (pair_max),
    .raddr (buf_addr),
    .rdata (buf_rd)
  );

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
    end else if (valid_in && !col[0]) begin
      h <= r;
    end
  end

  // Output registers; pool_out holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= win_done;
      frame_done <= win_done && last_col && last_row;
      if (win_done) begin
        pool_out <= {{(POOL_W - RELU_W){1'b0}}, win_max};
      end
    end
  end

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed bench for conv2_relu_pool on a 4x4 map, three bias variants.
// Latency: checks the result one cycle after the completing pixel.
// Backpressure: n/a; stimulus uses sparse and back-to-back strobes.
module tb_conv2_relu_pool;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [13:0] conv_in;
  logic [11:0] pool_o [3];
  logic        vld_o  [3];
  logic        fd_o   [3];

  int checks;
  int errors;
  int exp_last [3];

  // Instance 0: BIAS 0, instance 1: BIAS 50, instance 2: BIAS -5.
  conv2_relu_pool #(.IMG_W(4), .IMG_H(4), .BIAS(14'sd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .conv_in(conv_in),
    .pool_out(pool_o[0]), .valid_out(vld_o[0]), .frame_done(fd_o[0]));

  conv2_relu_pool #(.IMG_W(4), .IMG_H(4), .BIAS(14'sd50)) dut50 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .conv_in(conv_in),
    .pool_out(pool_o[1]), .valid_out(vld_o[1]), .frame_done(fd_o[1]));

  conv2_relu_pool #(.IMG_W(4), .IMG_H(4), .BIAS(-14'sd5)) dutm5 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .conv_in(conv_in),
    .pool_out(pool_o[2]), .valid_out(vld_o[2]), .frame_done(fd_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, then sample #1 after the rising edge.
  task automatic step(input logic v, input int d, input int sel,
                      input logic ev, input int ep, input logic efd,
                      input string tag);
    logic [11:0] exp_pool;
    valid_in = v;
    conv_in  = 14'(d);
    @(posedge clk);
    #1;
    if (ev) exp_last[sel] = ep;
    exp_pool = 12'(exp_last[sel]);
    checks++;
    assert (vld_o[sel] === ev) else begin
      errors++;
      $error("FAIL %s valid_out dut%0d observed %b expected %b", tag, sel, vld_o[sel], ev);
    end
    checks++;
    assert (pool_o[sel] === exp_pool) else begin
      errors++;
      $error("FAIL %s pool_out dut%0d observed %0d expected %0d", tag, sel, pool_o[sel], exp_pool);
    end
    checks++;
    assert (fd_o[sel] === efd) else begin
      errors++;
      $error("FAIL %s frame_done dut%0d observed %b expected %b", tag, sel, fd_o[sel], efd);
    end
  endtask

  // Hold reset for two cycles, checking the reset state of every instance.
  task automatic do_reset(input string tag);
    valid_in = 1'b0;
    conv_in  = '0;
    rst_n    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        assert (pool_o[k] === 12'd0 && vld_o[k] === 1'b0 && fd_o[k] === 1'b0) else begin
          errors++;
          $error("FAIL %s reset dut%0d observed pool=%0d vld=%b fd=%b expected 0/0/0",
                 tag, k, pool_o[k], vld_o[k], fd_o[k]);
        end
        exp_last[k] = 0;
      end
    end
    rst_n = 1'b1;
  endtask

  // One 4x4 frame; windows complete at pixel indices 5, 7, 13, 15.
  task automatic run_frame(input int sel, input int px[16], input int ex[4],
                           input int gap, input string tag);
    int   k;
    logic ev;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      ev = (i == 5 || i == 7 || i == 13 || i == 15);
      step(1'b1, px[i], sel, ev, ev ? ex[k] : 0, (i == 15), tag);
      if (ev) k++;
      for (int g = 0; g < gap; g++) step(1'b0, 0, sel, 1'b0, 0, 1'b0, tag);
    end
  endtask

  initial begin
    int px_inc [16];
    int px_dec [16];
    int px_neg [16];
    int px_big [16];
    int px_win [16];
    int ex_inc [4];
    int ex_dec [4];
    int ex_zero [4];
    int ex_sat [4];
    int ex_win [4];

    checks   = 0;
    errors   = 0;
    valid_in = 1'b0;
    conv_in  = '0;
    rst_n    = 1'b1;

    for (int i = 0; i < 16; i++) begin
      px_inc[i] = i + 1;
      px_dec[i] = 16 - i;
      px_neg[i] = -100;
      px_big[i] = 8000;
      px_win[i] = 0;
    end
    px_win[0] = 3;
    px_win[1] = 10;
    px_win[4] = 7;
    px_win[5] = 4;

    ex_inc  = '{6, 8, 14, 16};
    ex_dec  = '{16, 14, 8, 6};
    ex_zero = '{0, 0, 0, 0};
    ex_sat  = '{2047, 2047, 2047, 2047};
    ex_win  = '{5, 0, 0, 0};

    #2;
    do_reset("init");

    // Ramp frame on consecutive cycles.
    run_frame(0, px_inc, ex_inc, 0, "ramp");
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, "ramp_idle");

    // Same frame with a strobe only every third cycle.
    run_frame(0, px_inc, ex_inc, 2, "sparse");

    // Abort after pixel 9, then a clean frame.
    do_reset("pre_abort");
    for (int i = 0; i < 9; i++) begin
      step(1'b1, i + 1, 0, (i == 5 || i == 7), (i == 5) ? 6 : ((i == 7) ? 8 : 0),
           1'b0, "partial");
    end
    do_reset("abort");
    run_frame(0, px_inc, ex_inc, 0, "after_abort");

    // Two frames back-to-back, no idle cycle between.
    do_reset("pre_b2b");
    run_frame(0, px_inc, ex_inc, 0, "b2b_first");
    run_frame(0, px_dec, ex_dec, 0, "b2b_second");
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, "b2b_idle");

    // Negative sums clamp to zero; large sums saturate.
    do_reset("pre_clamp");
    run_frame(1, px_neg, ex_zero, 0, "relu_zero");
    run_frame(0, px_big, ex_sat, 0, "saturate");

    // Negative bias on a single hand-built window.
    do_reset("pre_bias");
    run_frame(2, px_win, ex_win, 0, "neg_bias");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_relu_pool.md
CONV2_RELU_POOL -- requirements
Module: conv2_relu_pool

Interface
REQ-001 Parameter IMG_W, default 12, conv2 feature-map width in pixels; SHALL be even and >= 2.
REQ-002 Parameter IMG_H, default 12, conv2 feature-map height in rows; SHALL be even and >= 2.
REQ-003 Parameter BIAS, default 0, signed 14-bit channel bias added to every input sample.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 valid_in  input  1  one-cycle strobe: conv_in carries one new pixel this cycle.
REQ-007 conv_in  input  14  signed conv2 channel sum for the current pixel, raster order.
REQ-008 pool_out  output  12  unsigned pooled result, 0..2047.
REQ-009 valid_out  output  1  one-cycle strobe qualifying pool_out.
REQ-010 frame_done  output  1  one-cycle strobe coincident with the last valid_out of a frame.

Function
REQ-011 Each accepted pixel SHALL be transformed as: s = sign-extend(conv_in, 15) + sign-extend(BIAS, 15); r = 0 if s < 0, 2047 if s > 2047, else s[10:0] (ReLU plus saturation).
REQ-012 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on valid_in; col wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
REQ-013 Gaps of any length between valid_in strobes SHALL NOT alter state or results.
REQ-014 Even col: r SHALL be held in pair register h.
REQ-015 Odd col, even row: max(h, r) SHALL be written to row buffer entry col/2 (IMG_W/2 entries x 11 bits); no output.
REQ-016 Odd col, odd row: m = max(buf[col/2], h, r) SHALL be registered to pool_out with valid_out = 1 on the next cycle (latency 1 cycle from the completing input).
REQ-017 valid_out SHALL be 0 in every other cycle; pool_out SHALL hold its last value when valid_out = 0.
REQ-018 Exactly (IMG_W/2)*(IMG_H/2) valid_out strobes SHALL be produced per frame, in raster order of pooled positions.
REQ-019 frame_done SHALL assert with the valid_out for row = IMG_H-1, col = IMG_W-1; back-to-back frames SHALL need no idle cycle.
REQ-020 pool_out[11] SHALL always be 0.
REQ-021 Row buffer entries SHALL be written on even rows before being read on the following odd row; no read-before-write hazard exists because entry col/2 is read only at the odd column of the odd row.

Reset
REQ-022 While rst_n = 0: col = 0, row = 0, h = 0, pool_out = 0, valid_out = 0, frame_done = 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; the first valid_in after release is pixel (0,0).
REQ-024 Row buffer contents need not be reset; REQ-021 guarantees they are never consumed stale.

Structure
REQ-025 Output width (12), internal ReLU width (11), and the saturation limit 2047 SHALL be constants in the shared CNN package used by the conv layers.
REQ-026 The row buffer SHALL be a sub-module pool_line_buf (one write port, one read port, depth parameter) so it maps to distributed RAM.
REQ-027 Counters, pair register, compare/max logic and output registers SHALL reside in the top module; no multipliers.

Verification (IMG_W = 4, IMG_H = 4, BIAS = 0 unless stated)
REQ-028 Frame of conv_in = 1..16 on consecutive cycles -> pool_out 6, 8, 14, 16, each one cycle after pixels 6, 8, 14, 16; frame_done with 16.
REQ-029 Same frame with valid_in on every third cycle only -> identical pool_out sequence, each valid_out one cycle after its completing input.
REQ-030 All conv_in = -100 with BIAS = 50 -> four outputs of 0; all conv_in = 8000 -> four outputs of 2047.
REQ-031 BIAS = -5, window {3, 10, 7, 4} at top-left -> pool_out 5.
REQ-032 rst_n pulsed low after pixel 9, then a full frame 1..16 -> no output from the aborted frame; outputs 6, 8, 14, 16.
REQ-033 Two frames back-to-back (32 consecutive strobes) -> 8 valid_out, frame_done twice, second frame results independent of the first.
